// File: rtl/pa_sysmap_pkg.sv
// rtl/pa_sysmap_pkg.sv - shared sysmap widths, miss default and attribute flag positions
package pa_sysmap_pkg;

  localparam int SYSMAP_ADDR_WIDTH = 20;
  localparam int SYSMAP_FLG_WIDTH  = 5;
  localparam logic [SYSMAP_FLG_WIDTH-1:0] SYSMAP_DEFAULT_FLG = 5'b10011;

  // Attribute flag bit positions as consumed by the LSU/IFU PMA check
  localparam int SYSMAP_FLG_SO  = 4;
  localparam int SYSMAP_FLG_C   = 3;
  localparam int SYSMAP_FLG_B   = 2;
  localparam int SYSMAP_FLG_SH  = 1;
  localparam int SYSMAP_FLG_SEC = 0;

endpackage

// File: rtl/pa_sysmap_region_cmp.sv
// rtl/pa_sysmap_region_cmp.sv - one region bound compare; ge_up feeds the next region's bottom
module pa_sysmap_region_cmp
  import pa_sysmap_pkg::*;
#(
  parameter int ADDR_WIDTH = SYSMAP_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] pa,
  input  logic [ADDR_WIDTH-1:0] upaddr,
  input  logic                  bottom_ge,
  output logic                  ge_up,
  output logic                  hit
);

  assign ge_up = !(pa < upaddr);
  assign hit   = bottom_ge && !ge_up;

endmodule

// File: rtl/pa_sysmap_lookup_pipe.sv
// rtl/pa_sysmap_lookup_pipe.sv - lockable region table with registered handshaked lookup
module pa_sysmap_lookup_pipe
  import pa_sysmap_pkg::*;
#(
  parameter int NUM_REGION = 8,
  parameter int ADDR_WIDTH = SYSMAP_ADDR_WIDTH,
  parameter int FLG_WIDTH  = SYSMAP_FLG_WIDTH,
  parameter int IDX_WIDTH  = 3,
  parameter logic [FLG_WIDTH-1:0] DEFAULT_FLG = SYSMAP_DEFAULT_FLG
) (
  input  logic                  forever_cpuclk,
  input  logic                  sysmap_rst,
  input  logic                  cfg_wr_vld,
  input  logic [IDX_WIDTH-1:0]  cfg_wr_idx,
  input  logic [ADDR_WIDTH-1:0] cfg_wr_upaddr,
  input  logic [FLG_WIDTH-1:0]  cfg_wr_flg,
  input  logic                  cfg_wr_lock,
  output logic                  cfg_wr_err,
  input  logic                  lkup_req_vld,
  output logic                  lkup_req_rdy,
  input  logic [ADDR_WIDTH-1:0] lkup_req_pa,
  output logic                  lkup_rsp_vld,
  input  logic                  lkup_rsp_rdy,
  output logic [FLG_WIDTH-1:0]  lkup_rsp_flg,
  output logic [IDX_WIDTH-1:0]  lkup_rsp_idx,
  output logic                  lkup_rsp_miss
);

  logic [ADDR_WIDTH-1:0] upaddr_q [NUM_REGION];
  logic [ADDR_WIDTH-1:0] upaddr_d [NUM_REGION];
  logic [FLG_WIDTH-1:0]  flg_q [NUM_REGION];
  logic [FLG_WIDTH-1:0]  flg_d [NUM_REGION];
  logic [NUM_REGION-1:0] lock_q, lock_d;
  logic [NUM_REGION-1:0] wr_sel;
  logic                  cfg_wr_err_q, cfg_wr_err_d;

  logic                  rsp_vld_q, rsp_vld_d;
  logic [FLG_WIDTH-1:0]  rsp_flg_q, rsp_flg_d;
  logic [IDX_WIDTH-1:0]  rsp_idx_q, rsp_idx_d;
  logic                  rsp_miss_q, rsp_miss_d;

  logic [NUM_REGION-1:0] ge_up, hit;
  logic [FLG_WIDTH-1:0]  hit_flg;
  logic [IDX_WIDTH-1:0]  hit_idx;
  logic                  hit_miss;
  logic                  req_accept;
  logic                  unused_top_ge;

  // An out-of-range index selects no entry, so it falls into the error path too
  always_comb begin
    wr_sel   = '0;
    upaddr_d = upaddr_q;
    flg_d    = flg_q;
    lock_d   = lock_q;
    for (int i = 0; i < NUM_REGION; i++) begin
      wr_sel[i] = cfg_wr_vld && (cfg_wr_idx == IDX_WIDTH'(i));
      if (wr_sel[i] && !lock_q[i]) begin
        upaddr_d[i] = cfg_wr_upaddr;
        flg_d[i]    = cfg_wr_flg;
        lock_d[i]   = cfg_wr_lock;
      end
    end
    cfg_wr_err_d = cfg_wr_vld && !(|(wr_sel & ~lock_q));
  end

  for (genvar g = 0; g < NUM_REGION; g++) begin : g_region
    logic bottom_ge;
    if (g == 0) begin : g_first
      assign bottom_ge = 1'b1;
    end else begin : g_chain
      assign bottom_ge = ge_up[g-1];
    end
    pa_sysmap_region_cmp #(.ADDR_WIDTH(ADDR_WIDTH)) u_cmp (
      .pa       (lkup_req_pa),
      .upaddr   (upaddr_q[g]),
      .bottom_ge(bottom_ge),
      .ge_up    (ge_up[g]),
      .hit      (hit[g])
    );
  end

  // The last region's upper compare has no successor to feed
  assign unused_top_ge = ge_up[NUM_REGION-1];

  always_comb begin
    hit_flg  = DEFAULT_FLG;
    hit_idx  = '0;
    hit_miss = 1'b1;
    for (int i = NUM_REGION - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_flg  = flg_q[i];
        hit_idx  = IDX_WIDTH'(i);
        hit_miss = 1'b0;
      end
    end
  end

  assign lkup_req_rdy = !rsp_vld_q || lkup_rsp_rdy;
  assign req_accept   = lkup_req_vld && lkup_req_rdy;

  always_comb begin
    rsp_vld_d  = rsp_vld_q;
    rsp_flg_d  = rsp_flg_q;
    rsp_idx_d  = rsp_idx_q;
    rsp_miss_d = rsp_miss_q;
    if (req_accept) begin
      rsp_vld_d  = 1'b1;
      rsp_flg_d  = hit_flg;
      rsp_idx_d  = hit_idx;
      rsp_miss_d = hit_miss;
    end else if (lkup_rsp_rdy) begin
      rsp_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (sysmap_rst) begin
      for (int i = 0; i < NUM_REGION; i++) begin
        upaddr_q[i] <= '0;
        flg_q[i]    <= '0;
      end
      lock_q       <= '0;
      cfg_wr_err_q <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_flg_q    <= '0;
      rsp_idx_q    <= '0;
      rsp_miss_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGION; i++) begin
        upaddr_q[i] <= upaddr_d[i];
        flg_q[i]    <= flg_d[i];
      end
      lock_q       <= lock_d;
      cfg_wr_err_q <= cfg_wr_err_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_flg_q    <= rsp_flg_d;
      rsp_idx_q    <= rsp_idx_d;
      rsp_miss_q   <= rsp_miss_d;
    end
  end

  assign cfg_wr_err    = cfg_wr_err_q;
  assign lkup_rsp_vld  = rsp_vld_q;
  assign lkup_rsp_flg  = rsp_flg_q;
  assign lkup_rsp_idx  = rsp_idx_q;
  assign lkup_rsp_miss = rsp_miss_q;

endmodule

// File: tb/tb_pa_sysmap_lookup_pipe.sv
// tb/tb_pa_sysmap_lookup_pipe.sv - vector table, corner sequences and random stimulus vs region model
module tb_pa_sysmap_lookup_pipe;

  localparam logic [4:0] DEF = 5'b10011;

  logic        clk = 1'b0;
  logic        sysmap_rst;
  logic        cfg_wr_vld;
  logic [2:0]  cfg_wr_idx;
  logic [19:0] cfg_wr_upaddr;
  logic [4:0]  cfg_wr_flg;
  logic        cfg_wr_lock;
  logic        cfg_wr_err;
  logic        lkup_req_vld;
  logic        lkup_req_rdy;
  logic [19:0] lkup_req_pa;
  logic        lkup_rsp_vld;
  logic        lkup_rsp_rdy;
  logic [4:0]  lkup_rsp_flg;
  logic [2:0]  lkup_rsp_idx;
  logic        lkup_rsp_miss;

  always #5 clk = ~clk;

  pa_sysmap_lookup_pipe dut (
    .forever_cpuclk(clk),
    .sysmap_rst    (sysmap_rst),
    .cfg_wr_vld    (cfg_wr_vld),
    .cfg_wr_idx    (cfg_wr_idx),
    .cfg_wr_upaddr (cfg_wr_upaddr),
    .cfg_wr_flg    (cfg_wr_flg),
    .cfg_wr_lock   (cfg_wr_lock),
    .cfg_wr_err    (cfg_wr_err),
    .lkup_req_vld  (lkup_req_vld),
    .lkup_req_rdy  (lkup_req_rdy),
    .lkup_req_pa   (lkup_req_pa),
    .lkup_rsp_vld  (lkup_rsp_vld),
    .lkup_rsp_rdy  (lkup_rsp_rdy),
    .lkup_rsp_flg  (lkup_rsp_flg),
    .lkup_rsp_idx  (lkup_rsp_idx),
    .lkup_rsp_miss (lkup_rsp_miss)
  );

  typedef struct {
    logic [19:0] pa;
    logic [4:0]  flg;
    logic [2:0]  idx;
    logic        miss;
  } vec_t;

  typedef struct {
    logic [4:0] flg;
    logic [2:0] idx;
    logic       miss;
  } rsp_t;

  int vectors = 0;
  int miscompares = 0;

  logic [19:0] m_up [8];
  logic [4:0]  m_flg [8];
  logic        m_lock [8];
  rsp_t        exp_q [$];
  vec_t        tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 8; i++) begin
      m_up[i] = '0;
      m_flg[i] = '0;
      m_lock[i] = 1'b0;
    end
    exp_q.delete();
  endtask

  // First region (lowest index) whose [bottom, top) contains pa
  function automatic rsp_t model_lookup(input logic [19:0] pa);
    rsp_t r;
    logic [19:0] bottom;
    r.flg = DEF;
    r.idx = 3'd0;
    r.miss = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bottom = (i == 0) ? 20'd0 : m_up[i-1];
      if (r.miss && pa >= bottom && pa < m_up[i]) begin
        r.flg = m_flg[i];
        r.idx = 3'(i);
        r.miss = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic cfg_write(input int idx, input logic [19:0] up, input logic [4:0] flg, input logic lock);
    logic exp_err;
    exp_err = m_lock[idx];
    cfg_wr_vld = 1'b1;
    cfg_wr_idx = 3'(idx);
    cfg_wr_upaddr = up;
    cfg_wr_flg = flg;
    cfg_wr_lock = lock;
    tick;
    cfg_wr_vld = 1'b0;
    cfg_wr_lock = 1'b0;
    check("cfg_wr_err", 32'(cfg_wr_err), 32'(exp_err));
    if (!exp_err) begin
      m_up[idx] = up;
      m_flg[idx] = flg;
      m_lock[idx] = lock;
    end
  endtask

  task automatic lookup_chk(input string name, input logic [19:0] pa, input logic [4:0] flg,
                            input logic [2:0] idx, input logic miss);
    lkup_req_vld = 1'b1;
    lkup_req_pa = pa;
    tick;
    lkup_req_vld = 1'b0;
    check({name, "_vld"}, 32'(lkup_rsp_vld), 32'd1);
    check({name, "_flg"}, 32'(lkup_rsp_flg), 32'(flg));
    check({name, "_idx"}, 32'(lkup_rsp_idx), 32'(idx));
    check({name, "_miss"}, 32'(lkup_rsp_miss), 32'(miss));
  endtask

  task automatic drain;
    lkup_req_vld = 1'b0;
    tick;
    check("rsp_drain", 32'(lkup_rsp_vld), 32'd0);
  endtask

  logic        r_wr, r_acc, r_hs, r_eerr;
  int          r_idx, r_k;
  rsp_t        r_exp;

  initial begin
    sysmap_rst = 1'b1;
    cfg_wr_vld = 1'b0;
    cfg_wr_idx = '0;
    cfg_wr_upaddr = '0;
    cfg_wr_flg = '0;
    cfg_wr_lock = 1'b0;
    lkup_req_vld = 1'b0;
    lkup_req_pa = '0;
    lkup_rsp_rdy = 1'b1;
    model_reset();
    tick;
    tick;
    sysmap_rst = 1'b0;
    check("rst_rsp_vld", 32'(lkup_rsp_vld), 32'd0);
    check("rst_rsp_flg", 32'(lkup_rsp_flg), 32'd0);
    check("rst_rsp_idx", 32'(lkup_rsp_idx), 32'd0);
    check("rst_rsp_miss", 32'(lkup_rsp_miss), 32'd0);
    check("rst_wr_err", 32'(cfg_wr_err), 32'd0);
    check("rst_req_rdy", 32'(lkup_req_rdy), 32'd1);

    lookup_chk("t1_empty", 20'h00000, DEF, 3'd0, 1'b1);
    drain();

    cfg_write(0, 20'h10000, 5'd1, 1'b0);
    cfg_write(1, 20'h20000, 5'd2, 1'b0);
    cfg_write(2, 20'h40000, 5'd3, 1'b0);
    tbl.push_back('{20'h1FFFF, 5'd2, 3'd1, 1'b0});
    tbl.push_back('{20'h20000, 5'd3, 3'd2, 1'b0});
    tbl.push_back('{20'h40000, DEF,  3'd0, 1'b1});
    tbl.push_back('{20'h00000, 5'd1, 3'd0, 1'b0});
    tbl.push_back('{20'h0FFFF, 5'd1, 3'd0, 1'b0});
    tbl.push_back('{20'h10000, 5'd2, 3'd1, 1'b0});
    tbl.push_back('{20'h3FFFF, 5'd3, 3'd2, 1'b0});
    tbl.push_back('{20'hFFFFF, DEF,  3'd0, 1'b1});
    for (int i = 0; i < tbl.size(); i++)
      lookup_chk("t2_mono", tbl[i].pa, tbl[i].flg, tbl[i].idx, tbl[i].miss);
    drain();

    cfg_write(0, 20'h30000, 5'd1, 1'b0);
    tbl.delete();
    tbl.push_back('{20'h10000, 5'd1, 3'd0, 1'b0});
    tbl.push_back('{20'h25000, 5'd1, 3'd0, 1'b0});
    tbl.push_back('{20'h35000, 5'd3, 3'd2, 1'b0});
    tbl.push_back('{20'h40000, DEF,  3'd0, 1'b1});
    for (int i = 0; i < tbl.size(); i++)
      lookup_chk("t3_prio", tbl[i].pa, tbl[i].flg, tbl[i].idx, tbl[i].miss);
    drain();

    // Back-pressure: first response parked while the next request waits
    lkup_rsp_rdy = 1'b0;
    lkup_req_vld = 1'b1;
    lkup_req_pa = 20'h05000;
    tick;
    lkup_req_pa = 20'h35000;
    for (int k = 0; k < 3; k++) begin
      check("t4_req_rdy_low", 32'(lkup_req_rdy), 32'd0);
      check("t4_hold_vld", 32'(lkup_rsp_vld), 32'd1);
      check("t4_hold_flg", 32'(lkup_rsp_flg), 32'd1);
      check("t4_hold_idx", 32'(lkup_rsp_idx), 32'd0);
      tick;
    end
    check("t4_hold_flg_end", 32'(lkup_rsp_flg), 32'd1);
    lkup_rsp_rdy = 1'b1;
    #1;
    check("t4_req_rdy_high", 32'(lkup_req_rdy), 32'd1);
    tick;
    check("t4_b2b0_vld", 32'(lkup_rsp_vld), 32'd1);
    check("t4_b2b0_flg", 32'(lkup_rsp_flg), 32'd3);
    check("t4_b2b0_idx", 32'(lkup_rsp_idx), 32'd2);
    lkup_req_pa = 20'h45000;
    tick;
    check("t4_b2b1_vld", 32'(lkup_rsp_vld), 32'd1);
    check("t4_b2b1_flg", 32'(lkup_rsp_flg), 32'(DEF));
    check("t4_b2b1_miss", 32'(lkup_rsp_miss), 32'd1);
    drain();

    cfg_write(0, 20'h10000, 5'd1, 1'b0);
    cfg_write(1, 20'h20000, 5'd2, 1'b1);
    cfg_write(1, 20'h38000, 5'h1F, 1'b0);
    tick;
    check("t5_err_pulse_end", 32'(cfg_wr_err), 32'd0);
    cfg_write(1, 20'h38000, 5'h1F, 1'b1);
    lookup_chk("t5_locked", 20'h18000, 5'd2, 3'd1, 1'b0);
    lookup_chk("t5_next", 20'h2FFFF, 5'd3, 3'd2, 1'b0);
    drain();
    lkup_req_vld = 1'b1;
    lkup_req_pa = 20'h45000;
    cfg_wr_vld = 1'b1;
    cfg_wr_idx = 3'd2;
    cfg_wr_upaddr = 20'h50000;
    cfg_wr_flg = 5'h07;
    tick;
    lkup_req_vld = 1'b0;
    cfg_wr_vld = 1'b0;
    m_up[2] = 20'h50000;
    m_flg[2] = 5'h07;
    check("t5_same_cyc_flg", 32'(lkup_rsp_flg), 32'(DEF));
    check("t5_same_cyc_miss", 32'(lkup_rsp_miss), 32'd1);
    check("t5_same_cyc_err", 32'(cfg_wr_err), 32'd0);
    lookup_chk("t5_after_wr", 20'h45000, 5'h07, 3'd2, 1'b0);
    drain();

    lkup_rsp_rdy = 1'b0;
    lkup_req_vld = 1'b1;
    lkup_req_pa = 20'h18000;
    tick;
    lkup_req_vld = 1'b0;
    check("t6_pre_vld", 32'(lkup_rsp_vld), 32'd1);
    sysmap_rst = 1'b1;
    tick;
    sysmap_rst = 1'b0;
    lkup_rsp_rdy = 1'b1;
    model_reset();
    check("t6_rst_vld", 32'(lkup_rsp_vld), 32'd0);
    check("t6_rst_flg", 32'(lkup_rsp_flg), 32'd0);
    lookup_chk("t6_miss_a", 20'h18000, DEF, 3'd0, 1'b1);
    lookup_chk("t6_miss_b", 20'h00000, DEF, 3'd0, 1'b1);
    drain();
    cfg_write(1, 20'h01000, 5'd4, 1'b0);

    // Random traffic against the queue-based reference
    sysmap_rst = 1'b1;
    tick;
    sysmap_rst = 1'b0;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      lkup_rsp_rdy = ($urandom_range(0, 3) != 0);
      lkup_req_vld = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 1) == 1) begin
        r_k = $urandom_range(0, 7);
        lkup_req_pa = m_up[r_k] + 20'($urandom_range(0, 2)) - 20'd1;
      end else begin
        lkup_req_pa = 20'($urandom_range(0, 20'hFFFFF));
      end
      r_wr = ($urandom_range(0, 3) == 0);
      r_idx = $urandom_range(0, 7);
      cfg_wr_vld = r_wr;
      cfg_wr_idx = 3'(r_idx);
      cfg_wr_upaddr = 20'($urandom_range(0, 15)) << 16;
      cfg_wr_flg = 5'($urandom_range(0, 31));
      cfg_wr_lock = ($urandom_range(0, 15) == 0);
      #1;
      check("rnd_req_rdy", 32'(lkup_req_rdy), 32'(exp_q.size() == 0 || lkup_rsp_rdy));
      r_acc = lkup_req_vld && (exp_q.size() == 0 || lkup_rsp_rdy);
      r_hs = (exp_q.size() != 0) && lkup_rsp_rdy;
      r_exp = model_lookup(lkup_req_pa);
      r_eerr = r_wr && m_lock[r_idx];
      tick;
      if (r_hs) void'(exp_q.pop_front());
      if (r_acc) exp_q.push_back(r_exp);
      if (r_wr && !m_lock[r_idx]) begin
        m_up[r_idx] = cfg_wr_upaddr;
        m_flg[r_idx] = cfg_wr_flg;
        m_lock[r_idx] = cfg_wr_lock;
      end
      check("rnd_rsp_vld", 32'(lkup_rsp_vld), 32'(exp_q.size() != 0));
      check("rnd_wr_err", 32'(cfg_wr_err), 32'(r_eerr));
      if (exp_q.size() != 0) begin
        check("rnd_rsp_flg", 32'(lkup_rsp_flg), 32'(exp_q[0].flg));
        check("rnd_rsp_idx", 32'(lkup_rsp_idx), 32'(exp_q[0].idx));
        check("rnd_rsp_miss", 32'(lkup_rsp_miss), 32'(exp_q[0].miss));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
